// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM port controller: access sizes, FSM states,
// port owner and the zero-extension mask used on load data.
package ram_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } ram_ctrl_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } ram_owner_t;

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = 32'h0000_00FF;
            SZ_HALF: size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Requester (fetch + data) and memory-side signal bundle of ram_port_ctrl.
// master = requesters and memory; slave = the controller.
interface ram_port_ctrl_if;

    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_size;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_fault;

    logic        ram_enable;
    logic        ram_rw;
    logic [7:0]  ram_addr;
    logic [1:0]  ram_size;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, ram_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_fault,
        input  ram_enable, ram_rw, ram_addr, ram_size, ram_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, ram_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata, d_fault,
        output ram_enable, ram_rw, ram_addr, ram_size, ram_wdata
    );

endinterface

// File: rtl/ram_arb_prio.sv
// Fetch/data tie-break: data normally wins, but after STARVE_MAX consecutive
// data grants with fetch waiting, fetch is forced through.
module ram_arb_prio #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic gnt_if_o,
    output logic gnt_d_o
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starved;

    always_comb begin
        starved      = (starve_cnt_q == SMAX);
        gnt_d_o      = arb_en_i && d_req_i && !(if_req_i && starved);
        gnt_if_o     = arb_en_i && if_req_i && !gnt_d_o;
        starve_cnt_d = starve_cnt_q;
        // The count only means something while fetch is actually waiting.
        if (!if_req_i || gnt_if_o) begin
            starve_cnt_d = '0;
        end else if (gnt_d_o && !starved) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Shares the single RAM256x8 port between fetch and data requesters with
// registered memory controls. Define RAM_ALIGN_CHECK_EN to reject misaligned accesses.
module ram_port_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            rst_n,
    ram_port_ctrl_if.slave bus
);

    ram_ctrl_state_t state_q, state_d;
    ram_owner_t      owner_q, owner_d;
    logic            fault_q, fault_d;
    logic            ram_en_q, ram_en_d;
    logic            ram_rw_q, ram_rw_d;
    logic [7:0]      ram_addr_q, ram_addr_d;
    logic [1:0]      ram_size_q, ram_size_d;
    logic [31:0]     ram_wdata_q, ram_wdata_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic gnt_if, gnt_d;
    logic d_rej, if_rej;

`ifdef RAM_ALIGN_CHECK_EN
    assign d_rej  = (bus.d_size == SZ_ILL)
                 || ((bus.d_size == SZ_HALF) && bus.d_addr[0])
                 || ((bus.d_size == SZ_WORD) && (bus.d_addr[1:0] != 2'b00));
    assign if_rej = (bus.if_addr[1:0] != 2'b00);
`else
    assign d_rej  = (bus.d_size == SZ_ILL);
    assign if_rej = 1'b0;
`endif

    ram_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_en_i (state_q == ST_IDLE),
        .if_req_i (bus.if_req),
        .d_req_i  (bus.d_req),
        .gnt_if_o (gnt_if),
        .gnt_d_o  (gnt_d)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        fault_d     = fault_q;
        ram_en_d    = 1'b0;
        ram_rw_d    = ram_rw_q;
        ram_addr_d  = ram_addr_q;
        ram_size_d  = ram_size_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // Memory controls load only here, so they are stable for all of ACCESS.
                if (gnt_d) begin
                    owner_d     = OWN_D;
                    fault_d     = d_rej;
                    ram_en_d    = !d_rej;
                    ram_rw_d    = bus.d_rw;
                    ram_addr_d  = bus.d_addr;
                    ram_size_d  = bus.d_size;
                    ram_wdata_d = bus.d_wdata;
                    state_d     = ST_ACCESS;
                end else if (gnt_if) begin
                    owner_d     = OWN_IF;
                    fault_d     = if_rej;
                    ram_en_d    = !if_rej;
                    ram_rw_d    = 1'b0;
                    ram_addr_d  = bus.if_addr;
                    ram_size_d  = SZ_WORD;
                    ram_wdata_d = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_en_q && !ram_rw_q) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = bus.ram_rdata & size_mask(ram_size_q);
                    end else begin
                        if_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            fault_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_size_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            fault_q     <= fault_d;
            ram_en_q    <= ram_en_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            ram_size_q  <= ram_size_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.ram_enable = ram_en_q;
    assign bus.ram_rw     = ram_rw_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_size   = ram_size_q;
    assign bus.ram_wdata  = ram_wdata_q;

    assign bus.if_ready  = (state_q == ST_ACCESS) && (owner_q == OWN_IF);
    assign bus.d_ready   = (state_q == ST_ACCESS) && (owner_q == OWN_D);
    assign bus.d_fault   = (state_q == ST_ACCESS) && (owner_q == OWN_D) && fault_q;
    assign bus.if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign bus.d_rvalid  = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: behavioural big-endian RAM, reference byte array and
// read-data scoreboards checked whenever an rvalid pulse appears.
module tb_ram_port_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] dq[$];
    logic [31:0] ifq[$];
    logic [31:0] last_d_exp = '0;
    logic [31:0] last_if_exp = '0;

    logic [7:0] mem[256];
    logic [7:0] ref_mem[256];

    ram_port_ctrl_if bus ();

    ram_port_ctrl #(
        .STARVE_MAX(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (bus.ram_size)
            2'b00:   bus.ram_rdata = {24'h0, mem[bus.ram_addr]};
            2'b01:   bus.ram_rdata = {16'h0, mem[bus.ram_addr], mem[bus.ram_addr + 8'd1]};
            default: bus.ram_rdata = {mem[bus.ram_addr], mem[bus.ram_addr + 8'd1],
                                      mem[bus.ram_addr + 8'd2], mem[bus.ram_addr + 8'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.ram_enable && bus.ram_rw) begin
            case (bus.ram_size)
                2'b00: mem[bus.ram_addr] <= bus.ram_wdata[7:0];
                2'b01: begin
                    mem[bus.ram_addr]        <= bus.ram_wdata[15:8];
                    mem[bus.ram_addr + 8'd1] <= bus.ram_wdata[7:0];
                end
                default: begin
                    mem[bus.ram_addr]        <= bus.ram_wdata[31:24];
                    mem[bus.ram_addr + 8'd1] <= bus.ram_wdata[23:16];
                    mem[bus.ram_addr + 8'd2] <= bus.ram_wdata[15:8];
                    mem[bus.ram_addr + 8'd3] <= bus.ram_wdata[7:0];
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.d_rvalid) begin
                tests++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL d_rvalid_unexpected got rvalid=1 exp rvalid=0 (t=%0t)", $time);
                end else begin
                    logic [31:0] e;
                    e = dq.pop_front();
                    if (bus.d_rdata !== e) begin
                        fails++;
                        $display("FAIL d_rdata got=%h exp=%h (t=%0t)", bus.d_rdata, e, $time);
                    end
                end
            end
            if (bus.if_rvalid) begin
                tests++;
                if (ifq.size() == 0) begin
                    fails++;
                    $display("FAIL if_rvalid_unexpected got rvalid=1 exp rvalid=0 (t=%0t)", $time);
                end else begin
                    logic [31:0] e;
                    e = ifq.pop_front();
                    if (bus.if_rdata !== e) begin
                        fails++;
                        $display("FAIL if_rdata got=%h exp=%h (t=%0t)", bus.if_rdata, e, $time);
                    end
                end
            end
        end
    end

    function automatic void ref_wr(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00: ref_mem[a] = d[7:0];
            2'b01: begin
                ref_mem[a]        = d[15:8];
                ref_mem[a + 8'd1] = d[7:0];
            end
            default: begin
                ref_mem[a]        = d[31:24];
                ref_mem[a + 8'd1] = d[23:16];
                ref_mem[a + 8'd2] = d[15:8];
                ref_mem[a + 8'd3] = d[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [7:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   ref_rd = {24'h0, ref_mem[a]};
            2'b01:   ref_rd = {16'h0, ref_mem[a], ref_mem[a + 8'd1]};
            default: ref_rd = {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
        endcase
    endfunction

    function automatic logic [112:0] outs();
        outs = {bus.if_ready, bus.if_rvalid, bus.if_rdata, bus.d_ready, bus.d_rvalid,
                bus.d_rdata, bus.d_fault, bus.ram_enable, bus.ram_rw, bus.ram_addr,
                bus.ram_size, bus.ram_wdata};
    endfunction

    // Drives one data request and waits (bounded) for its accept pulse.
    task automatic d_xfer(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                          input logic [31:0] wd, output bit ok, output bit flt,
                          output bit en, output int rc);
        bus.d_req = 1'b1; bus.d_rw = rw; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
        ok = 1'b0; flt = 1'b0; en = 1'b0; rc = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.d_ready) begin
                ok = 1'b1; flt = bus.d_fault; en = bus.ram_enable; rc = cyc;
            end
        end
        bus.d_req = 1'b0;
    endtask

    task automatic if_xfer(input logic [7:0] a, output bit ok, output bit en);
        bus.if_req = 1'b1; bus.if_addr = a;
        ok = 1'b0; en = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.if_ready) begin
                ok = 1'b1; en = bus.ram_enable;
            end
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL reset_outputs got=%h exp=0", outs());
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL idle_outputs got=%h exp=0", outs());
        end
    endtask

    task automatic test_store_load_word();
        bit ok, flt, en; int rc;
        d_xfer(1'b1, 2'b10, 8'h10, 32'hDEADBEEF, ok, flt, en, rc);
        ref_wr(8'h10, 2'b10, 32'hDEADBEEF);
        tests++;
        if ({ok, flt, en} !== 3'b101) begin
            fails++; $display("FAIL store_word_accept got ok/flt/en=%b exp=101", {ok, flt, en});
        end
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_size = 2'b10; bus.d_addr = 8'h10;
        dq.push_back(32'hDEADBEEF); last_d_exp = 32'hDEADBEEF;
        @(posedge clk); #1;
        tests++;
        if ({bus.d_ready, bus.d_rvalid, bus.ram_enable, bus.ram_addr} !== {3'b101, 8'h10}) begin
            fails++; $display("FAIL load_word_access got rdy/rv/en/addr=%b/%h exp=101/10",
                              {bus.d_ready, bus.d_rvalid, bus.ram_enable}, bus.ram_addr);
        end
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({bus.d_ready, bus.d_rvalid, bus.ram_enable} !== 3'b010) begin
            fails++; $display("FAIL load_word_resp got rdy/rv/en=%b exp=010",
                              {bus.d_ready, bus.d_rvalid, bus.ram_enable});
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_half_byte();
        bit ok, flt, en; int rc;
        logic [7:0]  la[3] = '{8'h21, 8'h20, 8'h20};
        logic [1:0]  ls[3] = '{2'b00, 2'b00, 2'b01};
        logic [31:0] le[3] = '{32'h0000_0034, 32'h0000_0012, 32'h0000_1234};
        d_xfer(1'b1, 2'b01, 8'h20, 32'h0000_1234, ok, flt, en, rc);
        ref_wr(8'h20, 2'b01, 32'h0000_1234);
        tests++;
        if ({ok, flt, en} !== 3'b101) begin
            fails++; $display("FAIL store_half_accept got ok/flt/en=%b exp=101", {ok, flt, en});
        end
        for (int i = 0; i < 3; i++) begin
            dq.push_back(le[i]); last_d_exp = le[i];
            d_xfer(1'b0, ls[i], la[i], 32'h0, ok, flt, en, rc);
            tests++;
            if ({ok, flt, en} !== 3'b101) begin
                fails++; $display("FAIL load_small_accept[%0d] got ok/flt/en=%b exp=101", i, {ok, flt, en});
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_fault();
        bit ok, flt, en; int rc;
        d_xfer(1'b0, 2'b11, 8'h10, 32'h0, ok, flt, en, rc);
        tests++;
        if ({ok, flt, en} !== 3'b110) begin
            fails++; $display("FAIL illegal_size got ok/flt/en=%b exp=110", {ok, flt, en});
        end
`ifdef RAM_ALIGN_CHECK_EN
        d_xfer(1'b0, 2'b10, 8'h13, 32'h0, ok, flt, en, rc);
        tests++;
        if ({ok, flt, en} !== 3'b110) begin
            fails++; $display("FAIL misaligned_word got ok/flt/en=%b exp=110", {ok, flt, en});
        end
        d_xfer(1'b0, 2'b01, 8'h11, 32'h0, ok, flt, en, rc);
        tests++;
        if ({ok, flt, en} !== 3'b110) begin
            fails++; $display("FAIL misaligned_half got ok/flt/en=%b exp=110", {ok, flt, en});
        end
        repeat (3) @(posedge clk);
        if_xfer(8'h02, ok, en);
        tests++;
        if ({ok, en} !== 2'b10) begin
            fails++; $display("FAIL misaligned_fetch got ok/en=%b exp=10", {ok, en});
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.if_rdata !== last_if_exp) begin
            fails++; $display("FAIL misaligned_fetch_rdata got=%h exp=%h", bus.if_rdata, last_if_exp);
        end
`else
        dq.push_back(ref_rd(8'h11, 2'b01)); last_d_exp = ref_rd(8'h11, 2'b01);
        d_xfer(1'b0, 2'b01, 8'h11, 32'h0, ok, flt, en, rc);
        tests++;
        if ({ok, flt, en} !== 3'b101) begin
            fails++; $display("FAIL unaligned_half_pass got ok/flt/en=%b exp=101", {ok, flt, en});
        end
`endif
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        bit ok, flt, en; int rc;
        d_xfer(1'b1, 2'b10, 8'h00, 32'hCAFEF00D, ok, flt, en, rc);
        ref_wr(8'h00, 2'b10, 32'hCAFEF00D);
        tests++;
        if ({ok, flt, en} !== 3'b101) begin
            fails++; $display("FAIL store_cafe_accept got ok/flt/en=%b exp=101", {ok, flt, en});
        end
        ifq.push_back(32'hCAFEF00D); last_if_exp = 32'hCAFEF00D;
        if_xfer(8'h00, ok, en);
        tests++;
        if ({ok, en, bus.ram_size} !== 4'b1110) begin
            fails++; $display("FAIL fetch_accept got ok/en/size=%b exp=1110", {ok, en, bus.ram_size});
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.d_rdata !== last_d_exp) begin
            fails++; $display("FAIL fetch_d_rdata_held got=%h exp=%h", bus.d_rdata, last_d_exp);
        end
        tests++;
        if (bus.if_rdata !== 32'hCAFEF00D) begin
            fails++; $display("FAIL fetch_rdata_held got=%h exp=cafef00d", bus.if_rdata);
        end
    endtask

    task automatic test_starve();
        bit g[10];
        int n = 0;
        ref_wr(8'h80, 2'b10, 32'h11223344);
        bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_size = 2'b10; bus.d_addr = 8'h80;
        bus.d_wdata = 32'h11223344;
        bus.if_req = 1'b1; bus.if_addr = 8'h00;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(posedge clk); #1;
            if (bus.d_ready) begin
                g[n] = 1'b1; n++;
            end else if (bus.if_ready) begin
                g[n] = 1'b0; n++;
                ifq.push_back(ref_rd(8'h00, 2'b10));
            end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        tests++;
        if (n != 10) begin
            fails++; $display("FAIL starve_grant_count got=%0d exp=10", n);
        end
        for (int k = 0; k < n; k++) begin
            tests++;
            if (g[k] !== (k % 5 != 4)) begin
                fails++; $display("FAIL starve_grant[%0d] got data=%0d exp data=%0d", k, g[k], (k % 5 != 4));
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit ok, flt, en; int rc[5];
        logic [7:0] ra[3] = '{8'h40, 8'h44, 8'h40};
        d_xfer(1'b1, 2'b10, 8'h40, 32'hA5A5_0F0F, ok, flt, en, rc[0]);
        ref_wr(8'h40, 2'b10, 32'hA5A5_0F0F);
        d_xfer(1'b1, 2'b10, 8'h44, 32'h1357_9BDF, ok, flt, en, rc[1]);
        ref_wr(8'h44, 2'b10, 32'h1357_9BDF);
        tests++;
        if (rc[1] - rc[0] != 2) begin
            fails++; $display("FAIL write_spacing got=%0d exp=2", rc[1] - rc[0]);
        end
        for (int i = 0; i < 3; i++) begin
            dq.push_back(ref_rd(ra[i], 2'b10)); last_d_exp = ref_rd(ra[i], 2'b10);
            d_xfer(1'b0, 2'b10, ra[i], 32'h0, ok, flt, en, rc[2 + i]);
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (rc[3 + i] - rc[2 + i] != 3) begin
                fails++; $display("FAIL read_spacing[%0d] got=%0d exp=3", i, rc[3 + i] - rc[2 + i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_during_write();
        bit ok, flt, en; int rc;
        d_xfer(1'b1, 2'b10, 8'h90, 32'hFFFF_0000, ok, flt, en, rc);
        tests++;
        if ({ok, en} !== 2'b11) begin
            fails++; $display("FAIL abort_write_accept got ok/en=%b exp=11", {ok, en});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.ram_enable, bus.d_ready} !== 2'b00) begin
            fails++; $display("FAIL async_reset_enable got en/rdy=%b exp=00", {bus.ram_enable, bus.d_ready});
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        last_d_exp = '0; last_if_exp = '0;
        #1;
        tests++;
        if (outs() !== '0) begin
            fails++; $display("FAIL post_reset_outputs got=%h exp=0", outs());
        end
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_size = 2'b10; bus.d_addr = 8'h40;
        dq.push_back(ref_rd(8'h40, 2'b10)); last_d_exp = ref_rd(8'h40, 2'b10);
        @(posedge clk); #1;
        tests++;
        if (bus.d_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_idle got rdy=%b exp=1", bus.d_ready);
        end
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_size = '0; bus.d_addr = '0; bus.d_wdata = '0;

        test_reset();
        test_store_load_word();
        test_half_byte();
        test_fault();
        test_fetch();
        test_starve();
        test_back_to_back();
        test_reset_during_write();

        tests++;
        if (dq.size() != 0 || ifq.size() != 0) begin
            fails++; $display("FAIL missing_rvalid got pending d=%0d if=%0d exp=0/0", dq.size(), ifq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
